// File: rtl/memoryer_pkg.sv
// Shared definitions for the memory stage: memory op encoding, decoded control
// bundle, FSM state codes and small op-classification helpers.
package memoryer_pkg;

  typedef enum logic [3:0] {
    MEM_NONE,
    LB,
    LH,
    LW,
    LBU,
    LHU,
    SB,
    SH,
    SW
  } mem_op_t;

  typedef struct packed {
    mem_op_t    mem_op;
    logic [4:0] rd;
  } control_info;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t RESP = 2'd2;

  function automatic logic is_store(mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Halfword ops need a[0]==0, word ops need a[1:0]==0.
  function automatic logic is_misaligned(mem_op_t op, logic [1:0] lo);
    case (op)
      LH, LHU, SH: return lo[0];
      LW, SW:      return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Lane offset actually used: offending low bits are dropped.
  function automatic logic [1:0] align_lo(mem_op_t op, logic [1:0] lo);
    case (op)
      LH, LHU, SH: return {lo[1], 1'b0};
      LW, SW:      return 2'b00;
      default:     return lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_aligner.sv
// Byte-lane logic: store strobes and lane replication, load extract and
// sign/zero extension. Purely combinational.
module mem_aligner
  import memoryer_pkg::*;
(
  input  mem_op_t     mem_op,
  input  logic [1:0]  lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [15:0] h;
  logic [7:0]  b;

  assign h = 16'(rdata >> {lo, 3'b000});
  assign b = h[7:0];

  always_comb begin
    wstrb     = 4'b0000;
    wdata     = 32'h0;
    load_data = 32'h0;
    case (mem_op)
      SB: begin
        wstrb = 4'b0001 << lo;
        wdata = {4{store_data[7:0]}};
      end
      SH: begin
        wstrb = 4'b0011 << lo;
        wdata = {2{store_data[15:0]}};
      end
      SW: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      LB:      load_data = {{24{b[7]}}, b};
      LBU:     load_data = {24'h0, b};
      LH:      load_data = {{16{h[15]}}, h};
      LHU:     load_data = {16'h0, h};
      LW:      load_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/memoryer.sv
// Memory stage: accepts one op at a time, runs a single data-memory access
// with a timeout, and emits a one-cycle writeback pulse.
// Optional feature: MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module memoryer
  import memoryer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  output logic        ready_out,
  input  control_info ctr_info,
  input  logic [31:0] exec_result,
  input  logic [31:0] rs2_val,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] mem_result,
  output logic [4:0]  rd_out,
  output logic        wb_en,
  output logic        bus_err,
  output logic        misaligned
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  mem_op_t       op;
  logic [4:0]    rd;
  logic [31:0]   addr;
  logic [31:0]   sdata;
  logic [CW-1:0] cnt;
  logic [31:0]   res;
  logic          wb, berr, mis;

  logic [3:0]    strb;
  logic [31:0]   wdat, ldat;
  logic          in_req, in_resp, accept, timeout, bad;

  mem_aligner u_aligner (
    .mem_op     (op),
    .lo         (addr[1:0]),
    .store_data (sdata),
    .rdata      (dmem_rdata),
    .wstrb      (strb),
    .wdata      (wdat),
    .load_data  (ldat)
  );

  assign in_req  = (state == REQ);
  assign in_resp = (state == RESP);
  assign accept  = valid_in && ready_out;
  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_CHECK_EN
  assign bad = is_misaligned(ctr_info.mem_op, exec_result[1:0]);
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
      op    <= MEM_NONE;
      rd    <= 5'd0;
      addr  <= 32'h0;
      sdata <= 32'h0;
      cnt   <= '0;
      res   <= 32'h0;
      wb    <= 1'b0;
      berr  <= 1'b0;
      mis   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op    <= ctr_info.mem_op;
          rd    <= ctr_info.rd;
          addr  <= {exec_result[31:2], align_lo(ctr_info.mem_op, exec_result[1:0])};
          sdata <= rs2_val;
          cnt   <= '0;
          berr  <= 1'b0;
          mis   <= 1'b0;
          if (ctr_info.mem_op == MEM_NONE) begin
            res   <= exec_result;
            wb    <= (ctr_info.rd != 5'd0);
            state <= RESP;
          end else if (bad) begin
            res   <= 32'h0;
            wb    <= 1'b0;
            mis   <= 1'b1;
            state <= RESP;
          end else begin
            state <= REQ;
          end
        end
        // ACK is checked first so a completion on the last allowed cycle wins.
        REQ: if (dmem_ack) begin
          res   <= is_store(op) ? 32'h0 : ldat;
          wb    <= !is_store(op) && (rd != 5'd0);
          state <= RESP;
        end else if (timeout) begin
          res   <= 32'h0;
          wb    <= 1'b0;
          berr  <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_out  = (state == IDLE);
  assign dmem_req   = in_req;
  assign dmem_we    = in_req && is_store(op);
  assign dmem_addr  = in_req ? {addr[31:2], 2'b00} : 32'h0;
  assign dmem_wstrb = in_req ? strb : 4'b0000;
  assign dmem_wdata = in_req ? wdat : 32'h0;

  assign valid_out  = in_resp;
  assign mem_result = in_resp ? res : 32'h0;
  assign rd_out     = in_resp ? rd : 5'd0;
  assign wb_en      = in_resp && wb;
  assign bus_err    = in_resp && berr;
  assign misaligned = in_resp && mis;

endmodule

// File: tb/tb_memoryer.sv
// Self-checking bench for memoryer: directed scenarios plus randomized ops
// checked against a byte-lane reference model.
module tb_memoryer;
  import memoryer_pkg::*;

  localparam int TO = 64;
`ifdef MISALIGN_CHECK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  control_info ctr_info;
  logic [31:0] exec_result = 32'h0, rs2_val = 32'h0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        valid_out;
  logic [31:0] mem_result;
  logic [4:0]  rd_out;
  logic        wb_en, bus_err, misaligned;

  memoryer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .ready_out(ready_out),
    .ctr_info(ctr_info), .exec_result(exec_result), .rs2_val(rs2_val),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .valid_out(valid_out), .mem_result(mem_result),
    .rd_out(rd_out), .wb_en(wb_en), .bus_err(bus_err), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Observations from the last issued op
  int          req_cycles, o_lat;
  logic        got_valid, valid_twice, stable, ready_before, req_at_valid;
  logic [31:0] o_addr, o_wdata, o_res;
  logic [3:0]  o_strb;
  logic        o_we, o_wb, o_berr, o_mis;
  logic [4:0]  o_rd;

  // ---------------- reference model ----------------
  function automatic int m_size(mem_op_t op);
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LW || op == SW) return 4;
    return 1;
  endfunction

  function automatic bit m_misaligned(mem_op_t op, logic [31:0] a);
    return MCHK && op != MEM_NONE && (a % m_size(op)) != 0;
  endfunction

  function automatic int m_off(mem_op_t op, logic [31:0] a);
    int o = a % 4;
    return o - (o % m_size(op));
  endfunction

  function automatic logic [3:0] m_strb(mem_op_t op, logic [31:0] a);
    int s = m_size(op);
    return 4'(((1 << s) - 1) << m_off(op, a));
  endfunction

  function automatic logic [31:0] m_wdata(mem_op_t op, logic [31:0] d);
    if (op == SB) return (d & 32'hFF) * 32'h0101_0101;
    if (op == SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(mem_op_t op, logic [31:0] a, logic [31:0] rdata);
    logic [31:0] v = rdata >> (8 * m_off(op, a));
    int x;
    case (op)
      LB:  begin x = int'(v & 32'hFF);   if (x > 127)   x -= 256;   return 32'(x); end
      LH:  begin x = int'(v & 32'hFFFF); if (x > 32767) x -= 65536; return 32'(x); end
      LBU: return v & 32'hFF;
      LHU: return v & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  // ---------------- driver: issue one op, collect observations ----------------
  // lat = number of REQ cycles before ACK (ACK in cycle lat); 0 = never ACK.
  task automatic issue(input mem_op_t op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rdata, input int lat);
    ready_before = ready_out;
    valid_in = 1'b1;
    ctr_info.mem_op = op;
    ctr_info.rd = rd;
    exec_result = a;
    rs2_val = d;
    dmem_rdata = rdata;
    @(posedge clk); @(negedge clk);
    valid_in = 1'b0;
    exec_result = $urandom;
    rs2_val = $urandom;
    ctr_info.rd = 5'($urandom);
    req_cycles = 0; got_valid = 0; valid_twice = 0; stable = 1; o_lat = -1;
    o_addr = 0; o_wdata = 0; o_strb = 0; o_we = 0;
    o_res = 0; o_wb = 0; o_berr = 0; o_mis = 0; o_rd = 0; req_at_valid = 0;
    for (int i = 0; i < TO + 20 && !got_valid; i++) begin
      dmem_ack = 1'b0;
      if (valid_out) begin
        got_valid = 1; o_lat = i; o_res = mem_result; o_wb = wb_en; o_berr = bus_err;
        o_mis = misaligned; o_rd = rd_out; req_at_valid = dmem_req;
      end else begin
        if (dmem_req) begin
          req_cycles++;
          if (req_cycles == 1) begin
            o_addr = dmem_addr; o_wdata = dmem_wdata; o_strb = dmem_wstrb; o_we = dmem_we;
          end else if (o_addr !== dmem_addr || o_wdata !== dmem_wdata ||
                       o_strb !== dmem_wstrb || o_we !== dmem_we) begin
            stable = 0;
          end
          if (req_cycles == lat) dmem_ack = 1'b1;
        end
        @(posedge clk); @(negedge clk);
      end
    end
    dmem_ack = 1'b0;
    if (got_valid) begin
      @(posedge clk); @(negedge clk);
      valid_twice = valid_out;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({ready_out, dmem_req, dmem_we, valid_out, wb_en, bus_err, misaligned} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 1000000",
               {ready_out, dmem_req, dmem_we, valid_out, wb_en, bus_err, misaligned});
    end
    vectors++;
    if ({dmem_addr, dmem_wdata, dmem_wstrb, mem_result, rd_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr %h wdata %h strb %b res %h rd %0d want all 0",
               dmem_addr, dmem_wdata, dmem_wstrb, mem_result, rd_out);
    end
    rstn = 1'b0;
  endtask

  task automatic test_alu();
    issue(MEM_NONE, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0);
    vectors++;
    if ({got_valid, o_lat, req_cycles} !== {1'b1, 32'sd0, 32'sd0}) begin
      miscompares++;
      $display("FAIL alu_timing: valid %b lat %0d req %0d want 1 0 0", got_valid, o_lat, req_cycles);
    end
    vectors++;
    if ({o_res, o_wb, o_rd} !== {32'h1234, 1'b1, 5'd5}) begin
      miscompares++;
      $display("FAIL alu_result: res %h wb %b rd %0d want 1234 1 5", o_res, o_wb, o_rd);
    end
    issue(MEM_NONE, 5'd0, 32'hCAFE_0001, 32'h0, 32'h0, 0);
    vectors++;
    if ({o_res, o_wb, valid_twice} !== {32'hCAFE_0001, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL alu_rd0: res %h wb %b twice %b want cafe0001 0 0", o_res, o_wb, valid_twice);
    end
  endtask

  task automatic test_load();
    issue(LB, 5'd7, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3);
    vectors++;
    if ({o_addr, o_we, req_cycles, o_lat} !== {32'h100, 1'b0, 32'sd3, 32'sd3}) begin
      miscompares++;
      $display("FAIL lb_access: addr %h we %b req %0d lat %0d want 100 0 3 3", o_addr, o_we, req_cycles, o_lat);
    end
    vectors++;
    if ({o_res, o_wb, o_berr, req_at_valid, valid_twice} !== {32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL lb_result: res %h wb %b berr %b req %b twice %b want ffffff80 1 0 0 0",
               o_res, o_wb, o_berr, req_at_valid, valid_twice);
    end
    // ACK in the very first REQ cycle: minimum latency
    issue(LHU, 5'd3, 32'h0000_0012, 32'h0, 32'h8765_4321, 1);
    vectors++;
    if ({o_lat, o_res} !== {32'sd1, 32'h0000_8765}) begin
      miscompares++;
      $display("FAIL lhu_fast: lat %0d res %h want 1 00008765", o_lat, o_res);
    end
  endtask

  task automatic test_store();
    issue(SH, 5'd9, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 2);
    vectors++;
    if ({o_strb, o_wdata, o_we, o_addr} !== {4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h200}) begin
      miscompares++;
      $display("FAIL sh_bus: strb %b wdata %h we %b addr %h want 1100 beefbeef 1 200",
               o_strb, o_wdata, o_we, o_addr);
    end
    vectors++;
    if ({got_valid, o_wb, o_res, stable} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL sh_result: valid %b wb %b res %h stable %b want 1 0 0 1", got_valid, o_wb, o_res, stable);
    end
  endtask

  task automatic test_timeout();
    issue(LW, 5'd4, 32'h0000_0040, 32'h0, 32'h1111_2222, 0);
    vectors++;
    if ({got_valid, req_cycles, req_at_valid} !== {1'b1, 32'(TO), 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_req: valid %b req %0d req_at_valid %b want 1 %0d 0",
               got_valid, req_cycles, req_at_valid, TO);
    end
    vectors++;
    if ({o_berr, o_wb, o_mis} !== 3'b100) begin
      miscompares++;
      $display("FAIL timeout_flags: berr %b wb %b mis %b want 1 0 0", o_berr, o_wb, o_mis);
    end
    // ACK on the last allowed cycle beats the timeout
    issue(LW, 5'd4, 32'h0000_0044, 32'h0, 32'h1111_2222, TO);
    vectors++;
    if ({o_berr, o_wb, o_res, req_cycles} !== {1'b0, 1'b1, 32'h1111_2222, 32'(TO)}) begin
      miscompares++;
      $display("FAIL ack_at_limit: berr %b wb %b res %h req %0d want 0 1 11112222 %0d",
               o_berr, o_wb, o_res, req_cycles, TO);
    end
  endtask

  task automatic test_stray_ack();
    int bad = 0;
    dmem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (valid_out || !ready_out || dmem_req) bad++;
    end
    dmem_ack = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL stray_ack: %0d bad idle cycles want 0", bad);
    end
  endtask

  task automatic test_misalign();
    issue(LW, 5'd6, 32'h0000_0002, 32'h0, 32'hA5A5_0F0F, 2);
    vectors++;
    if (MCHK) begin
      if ({req_cycles, o_mis, o_wb, got_valid} !== {32'sd0, 1'b1, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL misalign_on: req %0d mis %b wb %b valid %b want 0 1 0 1", req_cycles, o_mis, o_wb, got_valid);
      end
    end else begin
      if ({o_addr, o_mis, o_res, req_cycles} !== {32'h0, 1'b0, 32'hA5A5_0F0F, 32'sd2}) begin
        miscompares++;
        $display("FAIL misalign_off: addr %h mis %b res %h req %0d want 0 0 a5a50f0f 2",
                 o_addr, o_mis, o_res, req_cycles);
      end
    end
  endtask

  task automatic test_reset_mid_req();
    int bad = 0;
    valid_in = 1'b1; ctr_info.mem_op = LW; ctr_info.rd = 5'd8; exec_result = 32'h80;
    @(posedge clk); @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (dmem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_req_pre: dmem_req %b want 1", dmem_req);
    end
    rstn = 1'b1;
    @(posedge clk); @(negedge clk);
    rstn = 1'b0;
    dmem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (valid_out || !ready_out || dmem_req) bad++;
      @(posedge clk); @(negedge clk);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL mid_req_reset: %0d bad cycles after reset want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      mem_op_t     op = mem_op_t'($urandom_range(0, 8));
      logic [4:0]  rd = 5'($urandom);
      logic [31:0] a  = $urandom, d = $urandom, r = $urandom;
      int          lat = $urandom_range(1, 4);
      bit          mis = m_misaligned(op, a);
      bit          mem = (op != MEM_NONE) && !mis;
      bit          st  = (op == SB || op == SH || op == SW);
      logic [31:0] eres = (op == MEM_NONE) ? a : (!mem || st) ? 32'h0 : m_load(op, a, r);
      logic        ewb  = !mis && !st && (rd != 0);
      issue(op, rd, a, d, r, lat);
      vectors++;
      if ({ready_before, got_valid, valid_twice, o_berr, o_mis, o_rd} !==
          {1'b1, 1'b1, 1'b0, 1'b0, mis, rd}) begin
        miscompares++;
        $display("FAIL rnd_hs[%0d] op %0d: rdy %b v %b twice %b berr %b mis %b rd %0d want 1 1 0 0 %b %0d",
                 n, op, ready_before, got_valid, valid_twice, o_berr, o_mis, o_rd, mis, rd);
      end
      vectors++;
      if ({o_res, o_wb} !== {eres, ewb}) begin
        miscompares++;
        $display("FAIL rnd_res[%0d] op %0d a %h: res %h wb %b want %h %b", n, op, a, o_res, o_wb, eres, ewb);
      end
      vectors++;
      if ({req_cycles, o_lat} !== {mem ? lat : 0, mem ? lat : 0}) begin
        miscompares++;
        $display("FAIL rnd_lat[%0d] op %0d: req %0d lat %0d want %0d", n, op, req_cycles, o_lat, mem ? lat : 0);
      end
      if (mem) begin
        vectors++;
        if ({o_addr, o_we, stable} !== {a - (a % 4), st, 1'b1}) begin
          miscompares++;
          $display("FAIL rnd_bus[%0d] op %0d: addr %h we %b stable %b want %h %b 1",
                   n, op, o_addr, o_we, stable, a - (a % 4), st);
        end
        if (st) begin
          vectors++;
          if ({o_strb, o_wdata} !== {m_strb(op, a), m_wdata(op, d)}) begin
            miscompares++;
            $display("FAIL rnd_store[%0d] op %0d a %h: strb %b wdata %h want %b %h",
                     n, op, a, o_strb, o_wdata, m_strb(op, a), m_wdata(op, d));
          end
        end
      end
    end
  endtask

  initial begin
    ctr_info = '0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_stray_ack();
    test_misalign();
    test_reset_mid_req();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
